// File: rtl/buffer_pkgs.sv
// Shared execution/writeback payload types used by the CDB arbiter.
// Widths: ROB_PTR_W ROB tag, PREG_W physical register index, XLEN data.
package buffer_pkgs;

    localparam int unsigned ROB_PTR_W = 4;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned SRC_FU_W  = 2;

    typedef struct packed {
        logic                 completed;
        logic [PREG_W-1:0]    rd_addr;
        logic [XLEN-1:0]      rd_val;
        logic [ROB_PTR_W-1:0] rob_tag;
    } alu_out_t;

    typedef struct packed {
        logic                 completed;
        logic [PREG_W-1:0]    rd_addr;
        logic [XLEN-1:0]      rd_val;
        logic [ROB_PTR_W-1:0] rob_tag;
    } lsu_out_t;

    typedef struct packed {
        logic                 completed;
        logic [PREG_W-1:0]    rd_addr;
        logic [XLEN-1:0]      rd_val;
        logic [ROB_PTR_W-1:0] rob_tag;
        logic                 mispredict;
        logic                 branch_taken;
        logic [XLEN-1:0]      dest_addr;
    } branch_out_t;

    typedef struct packed {
        logic                 completed;
        logic [PREG_W-1:0]    rd_addr;
        logic [XLEN-1:0]      rd_val;
        logic [ROB_PTR_W-1:0] rob_tag;
        logic [SRC_FU_W-1:0]  src_fu;
        logic                 mispredict;
        logic                 branch_taken;
        logic [XLEN-1:0]      dest_addr;
    } wb_packet_t;

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// Bundle of unit result inputs, flush control and CDB output for the arbiter.
// slave  : arbiter view (results/flush in, ready/CDB out)
// master : producer / consumer view
interface wb_cdb_arbiter_if;
    import buffer_pkgs::*;

    alu_out_t             alu_out_i;
    logic                 alu_ready_o;
    lsu_out_t             lsu_out_i;
    logic                 lsu_ready_o;
    branch_out_t          br_out_i;
    logic                 br_ready_o;
    logic                 flush_i;
    logic [ROB_PTR_W-1:0] flush_tag_i;
    logic [ROB_PTR_W-1:0] rob_head_i;
    logic                 wb_valid_o;
    wb_packet_t           wb_o;

    modport slave (
        input  alu_out_i, lsu_out_i, br_out_i, flush_i, flush_tag_i, rob_head_i,
        output alu_ready_o, lsu_ready_o, br_ready_o, wb_valid_o, wb_o
    );

    modport master (
        output alu_out_i, lsu_out_i, br_out_i, flush_i, flush_tag_i, rob_head_i,
        input  alu_ready_o, lsu_ready_o, br_ready_o, wb_valid_o, wb_o
    );

endinterface

// File: rtl/wb_cdb_arbiter.sv
// Common data bus arbiter: per-unit shift queues for ALU, LSU and branch
// results, one writeback packet granted per cycle (branch first, ALU/LSU
// round-robin), with mispredict flush of results younger than the branch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_cdb_arbiter_if.slave (unit results + ready, flush,
//                ROB head, CDB valid/packet)
module wb_cdb_arbiter
    import buffer_pkgs::*;
#(
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_cdb_arbiter_if.slave bus
);

    localparam int unsigned N_UNITS = 3;
    localparam int unsigned U_ALU   = 0;
    localparam int unsigned U_LSU   = 1;
    localparam int unsigned U_BR    = 2;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    rr_e                rr_q, rr_d;
    wb_packet_t         q_r [N_UNITS][Q_DEPTH];
    wb_packet_t         q_d [N_UNITS][Q_DEPTH];
    logic               v_r [N_UNITS][Q_DEPTH];
    logic               v_d [N_UNITS][Q_DEPTH];

    logic [N_UNITS-1:0] ready;
    logic [N_UNITS-1:0] in_req;
    logic [N_UNITS-1:0] enq;
    logic [N_UNITS-1:0] pop;
    wb_packet_t         in_pkt [N_UNITS];
    wb_packet_t         head;
    logic               grant_any;
    logic               wb_valid;

    // Modular age relative to the ROB head; strictly greater age is younger.
    function automatic logic is_younger(input logic [ROB_PTR_W-1:0] tag,
                                        input logic [ROB_PTR_W-1:0] rob_head,
                                        input logic [ROB_PTR_W-1:0] ftag);
        logic [ROB_PTR_W-1:0] age_t;
        logic [ROB_PTR_W-1:0] age_f;
        age_t = tag - rob_head;
        age_f = ftag - rob_head;
        return age_t > age_f;
    endfunction

    // Ready only from registered occupancy: queue is compacted, so full == last slot valid.
    always_comb begin
        for (int u = 0; u < N_UNITS; u++) begin
            ready[u] = ~v_r[u][Q_DEPTH-1];
        end
    end

    assign bus.alu_ready_o = ready[U_ALU];
    assign bus.lsu_ready_o = ready[U_LSU];
    assign bus.br_ready_o  = ready[U_BR];

    // Map unit results onto the common writeback format at capture time.
    always_comb begin
        for (int u = 0; u < N_UNITS; u++) begin
            in_pkt[u] = '0;
        end
        in_req = '0;

        in_req[U_ALU]           = bus.alu_out_i.completed;
        in_pkt[U_ALU].completed = 1'b1;
        in_pkt[U_ALU].rd_addr   = bus.alu_out_i.rd_addr;
        in_pkt[U_ALU].rd_val    = bus.alu_out_i.rd_val;
        in_pkt[U_ALU].rob_tag   = bus.alu_out_i.rob_tag;
        in_pkt[U_ALU].src_fu    = SRC_FU_W'(0);

        in_req[U_LSU]           = bus.lsu_out_i.completed;
        in_pkt[U_LSU].completed = 1'b1;
        in_pkt[U_LSU].rd_addr   = bus.lsu_out_i.rd_addr;
        in_pkt[U_LSU].rd_val    = bus.lsu_out_i.rd_val;
        in_pkt[U_LSU].rob_tag   = bus.lsu_out_i.rob_tag;
        in_pkt[U_LSU].src_fu    = SRC_FU_W'(1);

        in_req[U_BR]              = bus.br_out_i.completed;
        in_pkt[U_BR].completed    = 1'b1;
        in_pkt[U_BR].rd_addr      = bus.br_out_i.rd_addr;
        in_pkt[U_BR].rd_val       = bus.br_out_i.rd_val;
        in_pkt[U_BR].rob_tag      = bus.br_out_i.rob_tag;
        in_pkt[U_BR].src_fu       = SRC_FU_W'(2);
        in_pkt[U_BR].mispredict   = bus.br_out_i.mispredict;
        in_pkt[U_BR].branch_taken = bus.br_out_i.branch_taken;
        in_pkt[U_BR].dest_addr    = bus.br_out_i.dest_addr;
    end

    // Arbitration from registered heads; a flushed head is still popped but not driven.
    always_comb begin
        pop       = '0;
        head      = '0;
        grant_any = 1'b0;
        rr_d      = rr_q;

        if (v_r[U_BR][0]) begin
            pop[U_BR] = 1'b1;
            head      = q_r[U_BR][0];
            grant_any = 1'b1;
        end else if (v_r[U_ALU][0] && (!v_r[U_LSU][0] || rr_q == RR_ALU)) begin
            pop[U_ALU] = 1'b1;
            head       = q_r[U_ALU][0];
            grant_any  = 1'b1;
            rr_d       = RR_LSU;
        end else if (v_r[U_LSU][0]) begin
            pop[U_LSU] = 1'b1;
            head       = q_r[U_LSU][0];
            grant_any  = 1'b1;
            rr_d       = RR_ALU;
        end

        wb_valid = grant_any &&
                   !(bus.flush_i && is_younger(head.rob_tag, bus.rob_head_i, bus.flush_tag_i));
    end

    assign bus.wb_valid_o = wb_valid;
    assign bus.wb_o       = wb_valid ? head : '0;

    // Next queue contents: drop popped/flushed entries, compact survivors, append new one.
    always_comb begin
        int k;
        enq = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            k = 0;
            for (int j = 0; j < Q_DEPTH; j++) begin
                q_d[u][j] = '0;
                v_d[u][j] = 1'b0;
            end
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (v_r[u][i] && !(pop[u] && i == 0) &&
                    !(bus.flush_i && is_younger(q_r[u][i].rob_tag, bus.rob_head_i, bus.flush_tag_i))) begin
                    for (int j = 0; j < Q_DEPTH; j++) begin
                        if (j == k) begin
                            q_d[u][j] = q_r[u][i];
                            v_d[u][j] = 1'b1;
                        end
                    end
                    k = k + 1;
                end
            end
            // Younger arrivals during a flush still complete the handshake but are discarded.
            enq[u] = in_req[u] && ready[u] &&
                     !(bus.flush_i && is_younger(in_pkt[u].rob_tag, bus.rob_head_i, bus.flush_tag_i));
            if (enq[u]) begin
                for (int j = 0; j < Q_DEPTH; j++) begin
                    if (j == k) begin
                        q_d[u][j] = in_pkt[u];
                        v_d[u][j] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_ALU;
            for (int u = 0; u < N_UNITS; u++) begin
                for (int j = 0; j < Q_DEPTH; j++) begin
                    q_r[u][j] <= '0;
                    v_r[u][j] <= 1'b0;
                end
            end
        end else begin
            rr_q <= rr_d;
            for (int u = 0; u < N_UNITS; u++) begin
                for (int j = 0; j < Q_DEPTH; j++) begin
                    q_r[u][j] <= q_d[u][j];
                    v_r[u][j] <= v_d[u][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Scoreboard bench for wb_cdb_arbiter: per-unit expected queues are filled on
// accepted handshakes and drained against CDB output through a reference
// arbitration/flush model, plus directed checks on the key scenarios.
module tb_wb_cdb_arbiter;
    import buffer_pkgs::*;

    localparam int Q_DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_cdb_arbiter_if bus_if ();

    wb_cdb_arbiter #(.Q_DEPTH(Q_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    alu_out_t    alu_stim[$];
    lsu_out_t    lsu_stim[$];
    branch_out_t br_stim[$];
    wb_packet_t  exp_a[$];
    wb_packet_t  exp_l[$];
    wb_packet_t  exp_b[$];

    bit         rr_lsu = 1'b0;
    bit         flush_now = 1'b0;
    logic [3:0] flush_tag = '0;
    logic [3:0] rob_head = '0;
    bit         last_valid;
    wb_packet_t last_pkt;
    int         hist[$];
    int         seen[16];
    bit         saw_alu_block;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit younger(input logic [3:0] t, input logic [3:0] h, input logic [3:0] f);
        logic [3:0] at;
        logic [3:0] af;
        at = t - h;
        af = f - h;
        return at > af;
    endfunction

    function automatic alu_out_t mk_alu(input int rd, input int val, input int tag);
        alu_out_t a;
        a = '0;
        a.completed = 1'b1;
        a.rd_addr = 7'(rd);
        a.rd_val = 32'(val);
        a.rob_tag = 4'(tag);
        return a;
    endfunction

    function automatic lsu_out_t mk_lsu(input int rd, input int val, input int tag);
        lsu_out_t l;
        l = '0;
        l.completed = 1'b1;
        l.rd_addr = 7'(rd);
        l.rd_val = 32'(val);
        l.rob_tag = 4'(tag);
        return l;
    endfunction

    function automatic branch_out_t mk_br(input int rd, input int val, input int tag,
                                          input bit mis, input bit tk, input int dest);
        branch_out_t b;
        b = '0;
        b.completed = 1'b1;
        b.rd_addr = 7'(rd);
        b.rd_val = 32'(val);
        b.rob_tag = 4'(tag);
        b.mispredict = mis;
        b.branch_taken = tk;
        b.dest_addr = 32'(dest);
        return b;
    endfunction

    function automatic wb_packet_t wb_of(input logic [6:0] rd, input logic [31:0] val,
                                         input logic [3:0] tag, input int fu,
                                         input bit mis, input bit tk, input logic [31:0] dest);
        wb_packet_t p;
        p = '0;
        p.completed = 1'b1;
        p.rd_addr = rd;
        p.rd_val = val;
        p.rob_tag = tag;
        p.src_fu = 2'(fu);
        p.mispredict = mis;
        p.branch_taken = tk;
        p.dest_addr = dest;
        return p;
    endfunction

    // One clock: drive held stimulus, check ready and CDB against the model, update model.
    task automatic cycle();
        wb_packet_t h;
        wb_packet_t tmp[$];
        bit has;
        bit ev;
        int sel;
        bit acc_a, acc_l, acc_b;
        alu_out_t a;
        lsu_out_t l;
        branch_out_t b;

        bus_if.alu_out_i   = (alu_stim.size() > 0) ? alu_stim[0] : '0;
        bus_if.lsu_out_i   = (lsu_stim.size() > 0) ? lsu_stim[0] : '0;
        bus_if.br_out_i    = (br_stim.size() > 0) ? br_stim[0] : '0;
        bus_if.flush_i     = flush_now;
        bus_if.flush_tag_i = flush_tag;
        bus_if.rob_head_i  = rob_head;
        @(negedge clk);

        chk("alu_ready", 128'(bus_if.alu_ready_o), 128'(exp_a.size() < Q_DEPTH));
        chk("lsu_ready", 128'(bus_if.lsu_ready_o), 128'(exp_l.size() < Q_DEPTH));
        chk("br_ready",  128'(bus_if.br_ready_o),  128'(exp_b.size() < Q_DEPTH));
        if (!bus_if.alu_ready_o) saw_alu_block = 1'b1;

        has = 1'b1;
        sel = 0;
        h = '0;
        if (exp_b.size() > 0) begin
            sel = 2; h = exp_b[0];
        end else if (exp_a.size() > 0 && (exp_l.size() == 0 || !rr_lsu)) begin
            sel = 0; h = exp_a[0];
        end else if (exp_l.size() > 0) begin
            sel = 1; h = exp_l[0];
        end else begin
            has = 1'b0;
        end
        ev = has && !(flush_now && younger(h.rob_tag, rob_head, flush_tag));
        chk("wb_valid", 128'(bus_if.wb_valid_o), 128'(ev));
        chk("wb_pkt", 128'(bus_if.wb_o), ev ? 128'(h) : 128'(0));

        last_valid = bus_if.wb_valid_o;
        last_pkt   = bus_if.wb_o;
        if (bus_if.wb_valid_o) begin
            hist.push_back(int'(bus_if.wb_o.src_fu));
            seen[bus_if.wb_o.rob_tag]++;
        end

        if (has) begin
            if (sel == 2) void'(exp_b.pop_front());
            else if (sel == 0) begin void'(exp_a.pop_front()); rr_lsu = 1'b1; end
            else begin void'(exp_l.pop_front()); rr_lsu = 1'b0; end
        end

        if (flush_now) begin
            tmp = {};
            foreach (exp_a[i]) if (!younger(exp_a[i].rob_tag, rob_head, flush_tag)) tmp.push_back(exp_a[i]);
            exp_a = tmp;
            tmp = {};
            foreach (exp_l[i]) if (!younger(exp_l[i].rob_tag, rob_head, flush_tag)) tmp.push_back(exp_l[i]);
            exp_l = tmp;
            tmp = {};
            foreach (exp_b[i]) if (!younger(exp_b[i].rob_tag, rob_head, flush_tag)) tmp.push_back(exp_b[i]);
            exp_b = tmp;
        end

        acc_a = (alu_stim.size() > 0) && bus_if.alu_ready_o;
        acc_l = (lsu_stim.size() > 0) && bus_if.lsu_ready_o;
        acc_b = (br_stim.size() > 0) && bus_if.br_ready_o;
        if (acc_a) begin
            a = alu_stim[0];
            if (!(flush_now && younger(a.rob_tag, rob_head, flush_tag)))
                exp_a.push_back(wb_of(a.rd_addr, a.rd_val, a.rob_tag, 0, 1'b0, 1'b0, 32'h0));
        end
        if (acc_l) begin
            l = lsu_stim[0];
            if (!(flush_now && younger(l.rob_tag, rob_head, flush_tag)))
                exp_l.push_back(wb_of(l.rd_addr, l.rd_val, l.rob_tag, 1, 1'b0, 1'b0, 32'h0));
        end
        if (acc_b) begin
            b = br_stim[0];
            if (!(flush_now && younger(b.rob_tag, rob_head, flush_tag)))
                exp_b.push_back(wb_of(b.rd_addr, b.rd_val, b.rob_tag, 2, b.mispredict,
                                      b.branch_taken, b.dest_addr));
        end

        @(posedge clk);
        #1;
        if (acc_a) void'(alu_stim.pop_front());
        if (acc_l) void'(lsu_stim.pop_front());
        if (acc_b) void'(br_stim.pop_front());
    endtask

    function automatic bit busy();
        return (alu_stim.size() + lsu_stim.size() + br_stim.size() +
                exp_a.size() + exp_l.size() + exp_b.size()) != 0;
    endfunction

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (busy() && n < max) begin
            cycle();
            n++;
        end
        chk(tag, 128'(busy()), 128'(0));
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 16; i++) seen[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        rst_n = 1'b0;
        bus_if.alu_out_i = '0;
        bus_if.lsu_out_i = '0;
        bus_if.br_out_i = '0;
        bus_if.flush_i = 1'b0;
        bus_if.flush_tag_i = '0;
        bus_if.rob_head_i = '0;
        clear_seen();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_ready", 128'(bus_if.alu_ready_o), 128'(1));
        chk("rst_lsu_ready", 128'(bus_if.lsu_ready_o), 128'(1));
        chk("rst_br_ready",  128'(bus_if.br_ready_o),  128'(1));
        chk("rst_wb_valid",  128'(bus_if.wb_valid_o),  128'(0));
        chk("rst_wb_o",      128'(bus_if.wb_o),        128'(0));
        rst_n = 1'b1;

        // Single ALU result: visible the cycle after acceptance, gone the next.
        alu_stim.push_back(mk_alu(5, 32'h1234, 3));
        cycle();
        chk("t1_c0_valid", 128'(last_valid), 128'(0));
        cycle();
        chk("t1_c1_valid", 128'(last_valid), 128'(1));
        chk("t1_rd",       128'(last_pkt.rd_addr), 128'(5));
        chk("t1_val",      128'(last_pkt.rd_val), 128'(32'h1234));
        chk("t1_tag",      128'(last_pkt.rob_tag), 128'(3));
        chk("t1_src",      128'(last_pkt.src_fu), 128'(0));
        chk("t1_cmp",      128'(last_pkt.completed), 128'(1));
        cycle();
        chk("t1_c2_valid", 128'(last_valid), 128'(0));

        // ALU and LSU streams together: strict alternation, backpressure, no loss.
        hist = {};
        saw_alu_block = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alu_stim.push_back(mk_alu(i + 1, 32'hA000 + i, i));
            lsu_stim.push_back(mk_lsu(i + 8, 32'hB000 + i, i + 6));
        end
        drain("t2_drain", 60);
        chk("t2_count", 128'(hist.size()), 128'(12));
        viol = 0;
        for (int i = 1; i < hist.size(); i++) if (hist[i] == hist[i-1]) viol++;
        chk("t2_alternate", 128'(viol), 128'(0));
        chk("t2_backpressure", 128'(saw_alu_block), 128'(1));

        // Branch beats a simultaneous ALU result.
        br_stim.push_back(mk_br(9, 32'h40, 7, 1'b1, 1'b1, 32'h100));
        alu_stim.push_back(mk_alu(10, 32'h55, 6));
        cycle();
        cycle();
        chk("t3_br_valid", 128'(last_valid), 128'(1));
        chk("t3_br_src",   128'(last_pkt.src_fu), 128'(2));
        chk("t3_br_dest",  128'(last_pkt.dest_addr), 128'(32'h100));
        chk("t3_br_mis",   128'(last_pkt.mispredict), 128'(1));
        cycle();
        chk("t3_alu_src",  128'(last_pkt.src_fu), 128'(0));
        chk("t3_alu_tag",  128'(last_pkt.rob_tag), 128'(6));
        drain("t3_drain", 10);

        // Wrap-around flush: head=14, flush tag 15 keeps 15, drops 0 and 1.
        rob_head = 4'd14;
        clear_seen();
        br_stim.push_back(mk_br(0, 32'h1, 14, 1'b0, 1'b0, 32'h200));
        br_stim.push_back(mk_br(0, 32'h2, 14, 1'b0, 1'b0, 32'h204));
        alu_stim.push_back(mk_alu(20, 32'hC15, 15));
        alu_stim.push_back(mk_alu(21, 32'hC01, 1));
        lsu_stim.push_back(mk_lsu(22, 32'hD00, 0));
        cycle();
        cycle();
        flush_now = 1'b1;
        flush_tag = 4'd15;
        cycle();
        flush_now = 1'b0;
        chk("t4_flush_valid", 128'(last_valid), 128'(1));
        chk("t4_flush_src",   128'(last_pkt.src_fu), 128'(2));
        drain("t4_drain", 10);
        chk("t4_seen15", 128'(seen[15]), 128'(1));
        chk("t4_seen0",  128'(seen[0]),  128'(0));
        chk("t4_seen1",  128'(seen[1]),  128'(0));

        // Selected head is younger during flush: masked and dropped; equal-age arrival kept.
        clear_seen();
        alu_stim.push_back(mk_alu(23, 32'hE02, 2));
        cycle();
        lsu_stim.push_back(mk_lsu(24, 32'hE15, 15));
        flush_now = 1'b1;
        flush_tag = 4'd15;
        cycle();
        flush_now = 1'b0;
        chk("t5_masked", 128'(last_valid), 128'(0));
        cycle();
        chk("t5_keep_valid", 128'(last_valid), 128'(1));
        chk("t5_keep_src",   128'(last_pkt.src_fu), 128'(1));
        chk("t5_keep_tag",   128'(last_pkt.rob_tag), 128'(15));
        drain("t5_drain", 10);
        chk("t5_seen2", 128'(seen[2]), 128'(0));

        // Async reset with ALU and LSU queues full, held off by branches.
        for (int i = 0; i < 4; i++) br_stim.push_back(mk_br(0, 32'h70 + i, 14, 1'b0, 1'b0, 32'h300));
        alu_stim.push_back(mk_alu(30, 32'hF0, 15));
        alu_stim.push_back(mk_alu(31, 32'hF1, 14));
        lsu_stim.push_back(mk_lsu(32, 32'hF2, 15));
        lsu_stim.push_back(mk_lsu(33, 32'hF3, 14));
        repeat (3) cycle();
        chk("t6_alu_full", 128'(bus_if.alu_ready_o), 128'(0));
        chk("t6_lsu_full", 128'(bus_if.lsu_ready_o), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_alu_ready", 128'(bus_if.alu_ready_o), 128'(1));
        chk("t6_rst_lsu_ready", 128'(bus_if.lsu_ready_o), 128'(1));
        chk("t6_rst_br_ready",  128'(bus_if.br_ready_o),  128'(1));
        chk("t6_rst_valid",     128'(bus_if.wb_valid_o),  128'(0));
        chk("t6_rst_wb",        128'(bus_if.wb_o),        128'(0));
        alu_stim = {}; lsu_stim = {}; br_stim = {};
        exp_a = {}; exp_l = {}; exp_b = {};
        rr_lsu = 1'b0;
        bus_if.alu_out_i = '0;
        bus_if.lsu_out_i = '0;
        bus_if.br_out_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();
        hist = {};
        alu_stim.push_back(mk_alu(34, 32'h11, 3));
        lsu_stim.push_back(mk_lsu(35, 32'h22, 4));
        drain("t6_drain", 10);
        chk("t6_first_alu", 128'((hist.size() > 0) ? hist[0] : 99), 128'(0));
        chk("t6_count", 128'(hist.size()), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the ALU, LSU and branch units. Each unit's output packet (alu_out_t, lsu_out_t, branch_out_t) is captured into a small per-unit queue. One wb_packet_t per cycle is granted onto the CDB, which feeds the PRF write port, RS wakeup and ROB completion. On a branch mispredict flush, queued results younger than the mispredicting branch are discarded.

Parameters:
Q_DEPTH, 2, entries per unit queue (>=1)
ROB_PTR_W, buffer_pkgs::ROB_PTR_W (4), ROB tag width
PREG_W, buffer_pkgs::PREG_W (7), physical register index width

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
alu_out_i  in  alu_out_t  ALU result; request = completed
alu_ready_o  out  1  ALU queue can accept
lsu_out_i  in  lsu_out_t  LSU result; request = completed
lsu_ready_o  out  1  LSU queue can accept
br_out_i  in  branch_out_t  branch result; request = completed
br_ready_o  out  1  branch queue can accept
flush_i  in  1  mispredict flush pulse from ROB
flush_tag_i  in  ROB_PTR_W  ROB tag of the mispredicting branch
rob_head_i  in  ROB_PTR_W  current ROB head (oldest) tag
wb_valid_o  out  1  CDB packet valid this cycle
wb_o  out  wb_packet_t  granted CDB packet

Behaviour:
- Reset (async, rst_n=0): all queues empty, all *_ready_o=1, wb_valid_o=0, wb_o all zero, round-robin pointer = ALU. Reset mid-operation discards all queued results.
- Enqueue: a unit's packet is accepted at the edge when completed=1 and ready_o=1. If ready_o=0, the packet is ignored. The producer holds completed and the data until it sees ready.
- ready_o = (occupancy < Q_DEPTH), taken from registered occupancy only. A same-cycle dequeue does not raise ready (conservative). No combinational path from wb_* to ready.
- Queue: in-order shift queue per unit. The head is slot 0, and the entry valid bits are kept.
- Arbitration: combinational from the registered queue heads.
  - Priority 1: the branch queue head always wins.
  - Otherwise ALU vs LSU is round-robin. The pointer toggles to the other unit after a grant to ALU or LSU, and is unchanged on a branch grant or an idle cycle.
  - A single non-empty ALU/LSU queue wins regardless of the pointer.
- Dequeue: the granted head pops at the same edge. The CDB never stalls.
- Latency: accepted at edge ending cycle N → earliest wb_valid_o in cycle N+1. Back-to-back results from one unit stream at 1 per cycle.
- Packet mapping (wb_o):
  - rd_addr, rd_val and ROB_tag are copied from the source packet.
  - completed=1.
  - ALU sets src_fu=0 and LSU sets src_fu=1. Both drive mispredict=0, branch_taken=0 and dest_addr=0.
  - Branch sets src_fu=2 and copies mispredict, branch_taken and dest_addr.
  - rd_addr=0 is passed unchanged and means no PRF write.
- When wb_valid_o=0, wb_o is driven all zero.
- Age rule: age(t) = (t - rob_head_i) mod 2^ROB_PTR_W. A tag is "younger" when age(t) > age(flush_tag_i).
- Flush (flush_i=1 in cycle F):
  - All queued entries with younger tags in every queue are invalidated at the edge ending F. Survivors keep their order and compact toward slot 0.
  - Incoming packets in F with younger tags are not enqueued. Their ready is still honoured, so the producer sees the handshake complete.
  - The grant in F is masked: if the selected head is younger, wb_valid_o=0 that cycle and the entry is dropped with no re-arbitration.
  - The mispredicting branch's own result (age equal to flush_tag_i) is retained.
- Simultaneous enqueue and dequeue on a full queue: the dequeue occurs, the enqueue is refused (ready was 0). Occupancy stays correct in every combination.

Test Plan:
- Reset then single ALU packet {rd=5, val=0x1234, tag=3} in cycle 0 → cycle 1: wb_valid_o=1, rd_addr=5, rd_val=0x1234, ROB_tag=3, src_fu=0, completed=1. Cycle 2: wb_valid_o=0.
- ALU and LSU packets in every cycle for 6 cycles, no branch → CDB grants alternate ALU, LSU, ALU… Queues fill to Q_DEPTH=2, ready drops, and no packet is lost or duplicated (scoreboard).
- Branch {tag=7, mispredict=1, dest=0x100} and ALU {tag=6} arrive together → branch is granted first (src_fu=2, dest_addr=0x100, mispredict=1), then the ALU packet next cycle.
- rob_head=14, queued ALU tags 15 and 1, LSU tag 0; flush_i with flush_tag=15 → tags 0 and 1 are dropped and tag 15 is still delivered. With head=14, wrap-around ordering is exercised.
- Flush in a cycle where the selected head is younger → wb_valid_o=0 that cycle, and the entry never appears later.
- Assert rst_n low for 1 cycle while both queues are full → asynchronously all ready=1, wb_valid_o=0, wb_o=0, and no stale packet appears after release.
